alu_pipe: RTL and testbench

//  Parametrised, pipelined integer ALU with valid/ready input handshake.
//  - Non-divide ops: fully pipelined, fixed latency 2, one op accepted per cycle.
//  - DIV/MOD: multi-cycle restoring divider; the block stalls input while dividing.
//  - Zero, carry/borrow, overflow and divide-by-zero flags are computed from the result being emitted.
//  - Sits between an operand source (sequencer/CPU datapath) and a result sink that never back-pressures.

---
 rtl/alu_pipe.sv | 145 ++++++++++++++
 tb/tb_alu_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined unsigned ALU with a multi-cycle restoring divider
// Ports: clk, rstn (async active-low); in_valid/in_ready operand handshake
// carrying opcode sel and operands A/B; out_valid pulses once per result on
// C with zero flag Z and carry/borrow/overflow/divide-by-zero flag CO.
module alu_pipe #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   sel,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         out_valid,
   output logic [W-1:0] C,
   output logic         Z,
   output logic         CO
);
   localparam int CW = $clog2(W + 1);
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t r_state, w_next;
   logic w_acc, w_is_div;
   logic r_s1_v;
   logic [2:0] r_s1_op;
   logic [W-1:0] r_s1_a, r_s1_b;
   logic r_s2_v, r_s2_co;
   logic [W-1:0] r_s2_c;
   logic [W-1:0] w_alu_c;
   logic w_alu_co;
   logic [W:0] w_sum, w_diff;
   logic [2*W-1:0] w_prod;
   logic [W-1:0] r_q, r_rem, r_d;
   logic r_mod;
   logic [CW-1:0] r_cnt;
   logic [W:0] w_shift, w_trial;
   logic w_emit_div;
   logic [W-1:0] w_o_c;
   logic w_o_co;
   assign w_acc = in_valid && in_ready;
   assign w_is_div = sel == 3'b011 || sel == 3'b100;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: w_next = (w_acc && w_is_div) ? DIV : IDLE;
         DIV: w_next = (r_cnt == CW'(1)) ? DONE : DIV;
         default: w_next = IDLE;
      endcase
   end
   always_comb in_ready = r_state == IDLE;
   // Restoring step: shift the next dividend bit into the partial remainder and
   // keep the subtraction only when it does not borrow. A zero divisor never
   // borrows, so the quotient fills with ones and the remainder ends equal to A.
   assign w_shift = {r_rem, r_q[W-1]};
   assign w_trial = w_shift - {1'b0, r_d};
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_q <= '0;
         r_rem <= '0;
         r_d <= '0;
         r_mod <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == IDLE && w_acc && w_is_div) begin
         r_q <= A;
         r_d <= B;
         r_rem <= '0;
         r_mod <= sel[2];
         r_cnt <= CW'(W);
      end else if (r_state == DIV) begin
         r_q <= {r_q[W-2:0], !w_trial[W]};
         r_rem <= w_trial[W] ? w_shift[W-1:0] : w_trial[W-1:0];
         r_cnt <= r_cnt - CW'(1);
      end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_s1_v <= 1'b0;
         r_s1_op <= '0;
         r_s1_a <= '0;
         r_s1_b <= '0;
      end else begin
         r_s1_v <= w_acc && !w_is_div;
         if (w_acc && !w_is_div) begin
            r_s1_op <= sel;
            r_s1_a <= A;
            r_s1_b <= B;
         end
      end
   assign w_sum = {1'b0, r_s1_a} + {1'b0, r_s1_b};
   assign w_diff = {1'b0, r_s1_a} - {1'b0, r_s1_b};
   assign w_prod = {{W{1'b0}}, r_s1_a} * {{W{1'b0}}, r_s1_b};
   always_comb begin
      w_alu_c = '0;
      w_alu_co = 1'b0;
      case (r_s1_op)
         3'b000: begin
            w_alu_c = w_sum[W-1:0];
            w_alu_co = w_sum[W];
         end
         3'b001: begin
            w_alu_c = w_diff[W-1:0];
            w_alu_co = w_diff[W];
         end
         3'b010: begin
            w_alu_c = w_prod[W-1:0];
            w_alu_co = |w_prod[2*W-1:W];
         end
         3'b101: w_alu_c = r_s1_a & r_s1_b;
         3'b110: w_alu_c = r_s1_a | r_s1_b;
         3'b111: w_alu_c = r_s1_a;
         default: w_alu_c = '0;
      endcase
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_s2_v <= 1'b0;
         r_s2_c <= '0;
         r_s2_co <= 1'b0;
      end else begin
         r_s2_v <= r_s1_v;
         r_s2_c <= w_alu_c;
         r_s2_co <= w_alu_co;
      end
   // Input is blocked through DIV/DONE, so a divide result and a pipeline
   // result can never compete for the output register in the same cycle.
   assign w_emit_div = r_state == DONE;
   assign w_o_c = w_emit_div ? (r_mod ? r_rem : r_q) : r_s2_c;
   assign w_o_co = w_emit_div ? (r_d == '0) : r_s2_co;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         out_valid <= 1'b0;
         C <= '0;
         Z <= 1'b0;
         CO <= 1'b0;
      end else begin
         out_valid <= w_emit_div || r_s2_v;
         if (w_emit_div || r_s2_v) begin
            C <= w_o_c;
            Z <= w_o_c == '0;
            CO <= w_o_co;
         end
      end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized scoreboard bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;
   localparam int W = 8;
   localparam int MAXV = (1 << W) - 1;
   logic clk, rstn, in_valid, in_ready, out_valid, Z, CO;
   logic [2:0] sel;
   logic [W-1:0] A, B, C;
   typedef struct {
      logic [W-1:0] c;
      logic co;
      int due;
   } exp_t;
   exp_t q[$];
   int n_chk = 0, n_fail = 0, edge_n = 0;
   bit div_busy = 0;
   int div_k = 0;
   logic [W-1:0] last_c = '0;
   logic last_z = 0, last_co = 0;
   alu_pipe #(.W(W)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .A(A), .B(B), .out_valid(out_valid), .C(C), .Z(Z), .CO(CO)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   always @(posedge clk) edge_n++;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask
   function automatic void model(input int s, input int a, input int b,
                                 output logic [W-1:0] c, output logic co);
      int r;
      r = 0;
      co = 0;
      case (s)
         0: begin r = a + b; co = r > MAXV; end
         1: begin r = a - b; co = a < b; end
         2: begin r = a * b; co = r > MAXV; end
         3: begin r = (b == 0) ? MAXV : a / b; co = b == 0; end
         4: begin r = (b == 0) ? a : a % b; co = b == 0; end
         5: r = a & b;
         6: r = a | b;
         default: r = a;
      endcase
      c = W'(r & MAXV);
   endfunction
   task automatic drive(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      int tries;
      bit done, rdy;
      exp_t e;
      tries = 0;
      done = 0;
      while (!done) begin
         @(negedge clk);
         in_valid = 1;
         sel = s;
         A = a;
         B = b;
         #1;
         rdy = !(div_busy && edge_n <= div_k + W);
         chk("in_ready", in_ready, rdy);
         if (rdy) begin
            model(s, int'(a), int'(b), e.c, e.co);
            e.due = edge_n + 1 + ((s == 3 || s == 4) ? W + 1 : 2);
            q.push_back(e);
            if (s == 3 || s == 4) begin
               div_busy = 1;
               div_k = edge_n + 1;
            end
            done = 1;
         end else if (!hold) done = 1;
         else if (++tries > 40) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready never rose");
            done = 1;
         end
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 0;
      end
   endtask
   task automatic do_reset(input int n);
      @(negedge clk);
      in_valid = 0;
      #2 rstn = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_C", C, 0);
      chk("rst_Z", Z, 0);
      chk("rst_CO", CO, 0);
      chk("rst_in_ready", in_ready, 1);
      q.delete();
      div_busy = 0;
      repeat (n) @(negedge clk);
      #2 rstn = 1;
   endtask
   always @(negedge clk) begin
      bit exp_v;
      exp_t e;
      if (!rstn) begin
         last_c = '0;
         last_z = 0;
         last_co = 0;
      end else begin
         exp_v = q.size() > 0 && q[0].due == edge_n;
         chk("out_valid", out_valid, exp_v);
         if (out_valid && q.size() > 0) begin
            e = q.pop_front();
            chk("C", C, e.c);
            chk("Z", Z, e.c == 0);
            chk("CO", CO, e.co);
            chk("latency_edge", edge_n, e.due);
            last_c = e.c;
            last_z = e.c == 0;
            last_co = e.co;
         end else begin
            if (exp_v) void'(q.pop_front());
            chk("hold_C", C, last_c);
            chk("hold_Z", Z, last_z);
            chk("hold_CO", CO, last_co);
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int cnt;
      rstn = 1;
      in_valid = 0;
      sel = 0;
      A = 0;
      B = 0;
      #1 rstn = 0;
      #1;
      chk("init_out_valid", out_valid, 0);
      chk("init_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      #2 rstn = 1;
      drive(0, 8'd1, 8'd2, 1);
      drive(2, 8'd9, 8'd9, 1);
      drive(7, 8'd3, 8'd0, 1);
      do_reset(2);
      drive(0, 8'd200, 8'd100, 1);
      drive(1, 8'd5, 8'd5, 1);
      idle(3);
      drive(2, 8'd16, 8'd17, 1);
      drive(2, 8'd3, 8'd4, 1);
      idle(3);
      drive(3, 8'd200, 8'd7, 1);
      @(negedge clk);
      in_valid = 0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (in_ready) break;
         cnt++;
         @(negedge clk);
      end
      chk("div_stall_len", cnt, 9);
      drive(4, 8'd200, 8'd7, 1);
      drive(3, 8'd37, 8'd0, 1);
      drive(0, 8'd1, 8'd1, 0);
      drive(6, 8'd2, 8'd4, 0);
      drive(5, 8'd7, 8'd7, 0);
      drive(4, 8'd37, 8'd0, 1);
      drive(1, 8'd3, 8'd200, 1);
      idle(12);
      drive(3, 8'd100, 8'd3, 1);
      idle(3);
      do_reset(2);
      idle(15);
      drive(7, 8'h5A, 8'h11, 1);
      idle(4);
      for (int i = 0; i < 300; i++) begin
         logic [2:0] s;
         logic [W-1:0] a, b;
         s = 3'($urandom_range(0, 7));
         a = W'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         drive(s, a, b, $urandom_range(0, 9) != 0);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(20);
      chk("drain_queue", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
